csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 163 ++++++++++++++++
 tb/tb_csr_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry/return and external interrupt handling at write-back.
// Optional feature macro: CSR_CYCLE_COUNTER_EN (64-bit cycle counter at 0xB00/0xB80, 0xC00/0xC80).
module csr_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  csr_op,
  input  logic        e_inter,
  input  logic [31:0] pcaddr,
  output logic [31:0] wb_data,
  output logic        pc_en,
  output logic [31:0] pc_data,
  output logic        flush
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_ECALL    = 12'h000;
  localparam logic [11:0] ADDR_EBREAK   = 12'h001;
  localparam logic [11:0] ADDR_MRET     = 12'h302;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [1:0]  mpp_q, mpp_d;
  logic        meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0] cycle_q, cycle_d;
`endif

  logic [31:0] csr_rdata;
  logic [31:0] csr_new;
  logic [31:0] trap_epc;
  logic        is_csr, is_sys, csr_we;
  logic        do_ecall, do_ebreak, do_mret, irq_take, trap_enter;

  // MPP is WARL with M-mode as the only legal value: reset clears it, any write or trap sets 11.
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = {19'h0, mpp_q, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
      ADDR_MIE:      csr_rdata = {20'h0, meie_q, 11'h0};
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MIP:      csr_rdata = {20'h0, e_inter, 11'h0};
`ifdef CSR_CYCLE_COUNTER_EN
      12'hB00, 12'hC00: csr_rdata = cycle_q[31:0];
      12'hB80, 12'hC80: csr_rdata = cycle_q[63:32];
`endif
      default:       csr_rdata = 32'h0;
    endcase
  end

  always_comb begin
    case (csr_op[1:0])
      2'b01:   csr_new = wdata;
      2'b10:   csr_new = csr_rdata | wdata;
      2'b11:   csr_new = csr_rdata & ~wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  assign is_csr     = (csr_op[1:0] != 2'b00);
  assign is_sys     = (csr_op == 3'b100);
  assign csr_we     = is_csr && ((csr_op[1:0] == 2'b01) || (wdata != 32'h0));
  assign irq_take   = e_inter && mie_q && meie_q && (pcaddr != 32'h0);
  assign do_ecall   = is_sys && (csr_addr == ADDR_ECALL);
  assign do_ebreak  = is_sys && (csr_addr == ADDR_EBREAK);
  assign do_mret    = is_sys && (csr_addr == ADDR_MRET);
  assign trap_enter = irq_take || do_ecall || do_ebreak;
  // A system instruction preempted by an interrupt never executes, so it is the return point.
  assign trap_epc   = (irq_take && !is_sys) ? pcaddr + 32'd4 : pcaddr;

  assign wb_data = is_csr ? csr_rdata : wdata;
  assign pc_en   = rst && (trap_enter || do_mret);
  assign flush   = pc_en;
  assign pc_data = trap_enter ? mtvec_q : (do_mret ? mepc_q : 32'h0);

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mpp_d      = mpp_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef CSR_CYCLE_COUNTER_EN
    cycle_d    = cycle_q + 64'd1;
`endif
    if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
          mpp_d  = 2'b11;
        end
        ADDR_MIE:      meie_d     = csr_new[11];
        ADDR_MTVEC:    mtvec_d    = {csr_new[31:2], 2'b00};
        ADDR_MSCRATCH: mscratch_d = csr_new;
        ADDR_MEPC:     mepc_d     = {csr_new[31:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = csr_new;
`ifdef CSR_CYCLE_COUNTER_EN
        12'hB00:       cycle_d    = {cycle_q[63:32], csr_new};
        12'hB80:       cycle_d    = {csr_new, cycle_q[31:0]};
`endif
        default: ;
      endcase
    end
    // Trap bookkeeping is applied last so it wins over a same-cycle CSR write.
    if (trap_enter) begin
      mepc_d   = {trap_epc[31:2], 2'b00};
      mcause_d = irq_take ? 32'h8000_000B : (do_ecall ? 32'd11 : 32'd3);
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mpp_d    = 2'b11;
    end else if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      mpp_d  = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      meie_q     <= 1'b0;
      mtvec_q    <= 32'h0;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
`ifdef CSR_CYCLE_COUNTER_EN
      cycle_q    <= 64'h0;
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
`ifdef CSR_CYCLE_COUNTER_EN
      cycle_q    <= cycle_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: the driver queues expected outputs, a negedge monitor checks them.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0]  csr_op = 3'b000;
  logic        e_inter = 1'b0;
  logic [31:0] pcaddr = 32'h0;
  logic [31:0] wb_data;
  logic        pc_en;
  logic [31:0] pc_data;
  logic        flush;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_RW   = 3'b001;
  localparam logic [2:0] OP_RS   = 3'b010;
  localparam logic [2:0] OP_RC   = 3'b011;
  localparam logic [2:0] OP_SYS  = 3'b100;

  csr_unit dut (
    .clk      (clk),
    .rst      (rst),
    .csr_addr (csr_addr),
    .wdata    (wdata),
    .csr_op   (csr_op),
    .e_inter  (e_inter),
    .pcaddr   (pcaddr),
    .wb_data  (wb_data),
    .pc_en    (pc_en),
    .pc_data  (pc_data),
    .flush    (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic        pcen;
    logic [31:0] pcd;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass   = 0;
  int   n_checks = 0;

  // Reference count of non-reset edges, the expected cycle counter value.
  longint unsigned tcyc = 0;
  always @(posedge clk) begin
    if (!rst) tcyc <= 0;
    else      tcyc <= tcyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".wb_data"}, wb_data, e.wb);
      check({e.tag, ".pc_en"},   {31'h0, pc_en}, {31'h0, e.pcen});
      check({e.tag, ".flush"},   {31'h0, flush}, {31'h0, e.pcen});
      check({e.tag, ".pc_data"}, pc_data, e.pcd);
      $display("txn %-14s op=%0d addr=%03h wdata=%08h pc=%08h irq=%0b -> wb=%08h pc_en=%0b pc_data=%08h",
               e.tag, csr_op, csr_addr, wdata, pcaddr, e_inter, wb_data, pc_en, pc_data);
    end
  end

  task automatic step(input logic r, input logic [2:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] pc, input logic ei,
                      input logic [31:0] ewb, input logic epen, input logic [31:0] epcd,
                      input string tag);
    exp_t e;
    rst = r; csr_op = op; csr_addr = a; wdata = wd; pcaddr = pc; e_inter = ei;
    e.wb = ewb; e.pcen = epen; e.pcd = epcd; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ev, input string tag);
    step(1'b1, OP_RS, a, 32'h0, 32'h200, 1'b0, ev, 1'b0, 32'h0, tag);
  endtask

  initial begin
    logic [31:0] cyc_a;
    logic [31:0] cyc_b;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Reset: outputs follow inputs, redirect suppressed, state cleared.
    step(1'b0, OP_SYS, 12'h000, 32'h55, 32'h40, 1'b0, 32'h55, 1'b0, 32'h0, "rst_ecall");
    step(1'b0, OP_RS, 12'h300, 32'h0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, "rst_mstatus");
    // mtvec write with low bits masked.
    step(1'b1, OP_RW, 12'h305, 32'h103, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, "mtvec_rw");
    rd(12'h305, 32'h100, "mtvec_rd");
    step(1'b1, OP_NONE, 12'h305, 32'hCAFE, 32'h14, 1'b0, 32'hCAFE, 1'b0, 32'h0, "plain_op");
    // mstatus set/clear.
    step(1'b1, OP_RS, 12'h300, 32'h8, 32'h18, 1'b0, 32'h0, 1'b0, 32'h0, "mstatus_rs");
    rd(12'h300, 32'h1808, "mstatus_rd1");
    step(1'b1, OP_RC, 12'h300, 32'h8, 32'h1C, 1'b0, 32'h1808, 1'b0, 32'h0, "mstatus_rc");
    rd(12'h300, 32'h1800, "mstatus_rd2");
    // ECALL / EBREAK.
    step(1'b1, OP_SYS, 12'h000, 32'h0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, "ecall");
    rd(12'h341, 32'h40, "ecall_mepc");
    rd(12'h342, 32'd11, "ecall_mcause");
    step(1'b1, OP_SYS, 12'h001, 32'h0, 32'h44, 1'b0, 32'h0, 1'b1, 32'h100, "ebreak");
    rd(12'h342, 32'd3, "ebreak_mcause");
    // Enable interrupts.
    step(1'b1, OP_RS, 12'h300, 32'h8, 32'h48, 1'b0, 32'h1800, 1'b0, 32'h0, "set_mie");
    step(1'b1, OP_RW, 12'h304, 32'hFFFF_FFFF, 32'h4C, 1'b0, 32'h0, 1'b0, 32'h0, "mie_rw");
    rd(12'h304, 32'h800, "mie_rd");
    // Bubble suppresses the interrupt; mip reflects the line.
    step(1'b1, OP_RS, 12'h344, 32'h0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h0, "irq_bubble");
    step(1'b1, OP_NONE, 12'h000, 32'hABCD, 32'h80, 1'b1, 32'hABCD, 1'b1, 32'h100, "irq_add");
    rd(12'h341, 32'h84, "irq_mepc");
    rd(12'h342, 32'h8000_000B, "irq_mcause");
    rd(12'h300, 32'h1880, "irq_mstatus");
    // MRET.
    step(1'b1, OP_SYS, 12'h302, 32'h0, 32'h90, 1'b0, 32'h0, 1'b1, 32'h84, "mret");
    rd(12'h300, 32'h1888, "mret_mstatus");
    // Interrupt alongside a CSR write: the write still lands.
    step(1'b1, OP_RW, 12'h340, 32'hDEAD_BEEF, 32'hA0, 1'b1, 32'h0, 1'b1, 32'h100, "irq_csrrw");
    rd(12'h340, 32'hDEAD_BEEF, "mscratch_rd");
    rd(12'h341, 32'hA4, "irq2_mepc");
    step(1'b1, OP_SYS, 12'h302, 32'h0, 32'hB0, 1'b0, 32'h0, 1'b1, 32'hA4, "mret2");
    // Interrupt beats ECALL; ECALL not executed so mepc is its own PC.
    step(1'b1, OP_SYS, 12'h000, 32'h0, 32'hC0, 1'b1, 32'h0, 1'b1, 32'h100, "irq_vs_ecall");
    rd(12'h342, 32'h8000_000B, "irq3_mcause");
    rd(12'h341, 32'hC0, "irq3_mepc");
    // Unimplemented address and unknown system op.
    step(1'b1, OP_RW, 12'h7C0, 32'h1234, 32'hC4, 1'b0, 32'h0, 1'b0, 32'h0, "unimpl_rw");
    rd(12'h7C0, 32'h0, "unimpl_rd");
    step(1'b1, OP_SYS, 12'h105, 32'h77, 32'hD0, 1'b0, 32'h77, 1'b0, 32'h0, "sys_nop");
    // Cycle counter: two reads five cycles apart.
`ifdef CSR_CYCLE_COUNTER_EN
    cyc_a = tcyc[31:0];
`else
    cyc_a = 32'h0;
`endif
    rd(12'hC00, cyc_a, "cycle_rd1");
    for (int i = 0; i < 4; i++)
      step(1'b1, OP_NONE, 12'h0, i, 32'hE0, 1'b0, i, 1'b0, 32'h0, "filler");
`ifdef CSR_CYCLE_COUNTER_EN
    cyc_b = cyc_a + 32'd5;
`else
    cyc_b = 32'h0;
`endif
    rd(12'hC00, cyc_b, "cycle_rd2");
    rd(12'hC80, 32'h0, "cycle_hi");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
